// File: rtl/reg_bank_pair.sv
// Byte-addressable register file with a 16-bit pair view and a small
// sequencer for two-beat pair loads and two-cycle pair increment/decrement.
module reg_bank_pair #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [SEL_W-1:0]      wr_sel,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [SEL_W-1:0]      rd_a_sel,
    output logic [DATA_W-1:0]     rd_a_data,
    input  logic [SEL_W-1:0]      rd_b_sel,
    output logic [DATA_W-1:0]     rd_b_data,
    input  logic [SEL_W-2:0]      pair_rd_sel,
    output logic [2*DATA_W-1:0]   pair_rd_data,
    input  logic                  pair_op_valid,
    output logic                  pair_op_ready,
    input  logic [1:0]            pair_op,
    input  logic [SEL_W-2:0]      pair_op_sel,
    input  logic [DATA_W-1:0]     pair_op_data,
    output logic                  pair_op_done,
    output logic                  pair_zero,
    output logic                  wr_conflict
);

    localparam int unsigned PAIR_W = SEL_W - 1;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_HI = 2'd1,
        ADJ_HI  = 2'd2
    } state_t;

    logic [DATA_W-1:0] regs [NUM_REGS];

    state_t            state, state_nxt;
    logic [PAIR_W-1:0] lat_p, lat_p_nxt;
    logic              lat_carry, lat_carry_nxt;
    logic              lat_dec, lat_dec_nxt;

    logic              pw_en;
    logic [SEL_W-1:0]  pw_idx;
    logic [DATA_W-1:0] pw_data;
    logic              done_nxt;
    logic              zero_upd;
    logic              zero_nxt;
    logic              drop_c;
    logic [DATA_W-1:0] low_cur, high_cur, high_new;

    // Sequencer next-state and the single pair-side register write it issues
    always_comb begin
        state_nxt     = state;
        lat_p_nxt     = lat_p;
        lat_carry_nxt = lat_carry;
        lat_dec_nxt   = lat_dec;
        pw_en         = 1'b0;
        pw_idx        = '0;
        pw_data       = '0;
        done_nxt      = 1'b0;
        zero_upd      = 1'b0;
        low_cur       = regs[{pair_op_sel, 1'b1}];
        high_cur      = regs[{lat_p, 1'b0}];
        high_new      = lat_dec ? (high_cur - DATA_W'(lat_carry))
                                : (high_cur + DATA_W'(lat_carry));
        zero_nxt      = ({high_new, regs[{lat_p, 1'b1}]} == '0);

        case (state)
            IDLE: begin
                if (pair_op_valid) begin
                    case (pair_op)
                        OP_LOAD: begin
                            pw_en     = 1'b1;
                            pw_idx    = {pair_op_sel, 1'b1};
                            pw_data   = pair_op_data;
                            lat_p_nxt = pair_op_sel;
                            state_nxt = LOAD_HI;
                        end
                        OP_INC: begin
                            pw_en         = 1'b1;
                            pw_idx        = {pair_op_sel, 1'b1};
                            pw_data       = low_cur + DATA_W'(1);
                            lat_p_nxt     = pair_op_sel;
                            lat_carry_nxt = (low_cur == '1);
                            lat_dec_nxt   = 1'b0;
                            state_nxt     = ADJ_HI;
                        end
                        OP_DEC: begin
                            pw_en         = 1'b1;
                            pw_idx        = {pair_op_sel, 1'b1};
                            pw_data       = low_cur - DATA_W'(1);
                            lat_p_nxt     = pair_op_sel;
                            lat_carry_nxt = (low_cur == '0);
                            lat_dec_nxt   = 1'b1;
                            state_nxt     = ADJ_HI;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD_HI: begin
                // Second beat always targets the latched pair, whatever op/sel say
                if (pair_op_valid) begin
                    pw_en     = 1'b1;
                    pw_idx    = {lat_p, 1'b0};
                    pw_data   = pair_op_data;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ADJ_HI: begin
                pw_en     = 1'b1;
                pw_idx    = {lat_p, 1'b0};
                pw_data   = high_new;
                done_nxt  = 1'b1;
                zero_upd  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A byte write colliding with the pair write loses
    assign drop_c = wr_en && pw_en && (wr_sel == pw_idx);

    // Sequencer state, latched operands and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lat_p        <= '0;
            lat_carry    <= 1'b0;
            lat_dec      <= 1'b0;
            pair_op_done <= 1'b0;
            pair_zero    <= 1'b0;
            wr_conflict  <= 1'b0;
        end else begin
            state        <= state_nxt;
            lat_p        <= lat_p_nxt;
            lat_carry    <= lat_carry_nxt;
            lat_dec      <= lat_dec_nxt;
            pair_op_done <= done_nxt;
            wr_conflict  <= drop_c;
            if (zero_upd) pair_zero <= zero_nxt;
        end
    end

    // Register array: byte port and pair port never hit the same entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
        end else begin
            if (wr_en && !drop_c) regs[wr_sel] <= wr_data;
            if (pw_en)            regs[pw_idx] <= pw_data;
        end
    end

    // Read ports; only the byte ports see same-cycle write data
    assign rd_a_data = ((BYPASS != 0) && wr_en && !drop_c && (wr_sel == rd_a_sel))
                       ? wr_data : regs[rd_a_sel];
    assign rd_b_data = ((BYPASS != 0) && wr_en && !drop_c && (wr_sel == rd_b_sel))
                       ? wr_data : regs[rd_b_sel];
    assign pair_rd_data  = {regs[{pair_rd_sel, 1'b0}], regs[{pair_rd_sel, 1'b1}]};
    assign pair_op_ready = !rst && (state != ADJ_HI);

endmodule
